// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - data-memory request/response bus between the MEM stage and the data memory
interface mem_access_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - pipeline MEM stage with byte/word data-memory access; optional timeout under MEM_ACCESS_TIMEOUT_EN
module mem_access_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic        ex_write,
    input  logic        ex_quarter,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    input  logic [4:0]  ex_rd,
    input  logic [31:0] ex_result,
    input  logic        stall_i,
    output logic        stall_o,
    mem_access_stage_if.master mem,
    output logic        wb_valid,
    output logic        wb_write,
    output logic        wb_quarter,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        fault_o
);
    typedef enum logic [1:0] {IDLE, ACCESS, HOLD} state_t;

    state_t      state, next_state;
    logic        is_mem, accept, expire, done, timed_out;
    logic        op_we, op_quarter, op_write;
    logic [1:0]  op_lane;
    logic [3:0]  op_be;
    logic [4:0]  op_rd;
    logic [31:0] op_addr, op_wdata, op_result;
    logic [31:0] load_data, res_data;
    logic        res_write;
    logic        hold_write;
    logic [31:0] hold_data;

    assign is_mem = ex_mem_read | ex_mem_write;
    assign accept = (state == IDLE) & ex_valid & ~stall_i;

`ifdef MEM_ACCESS_TIMEOUT_EN
    logic [3:0] cnt;
    logic       fault_q;
    // cnt == 15 means this is the 16th ACCESS cycle without an ack
    assign expire  = (state == ACCESS) & (cnt == 4'hF);
    assign fault_o = fault_q;
`else
    assign expire  = 1'b0;
    assign fault_o = 1'b0;
`endif

    // an ack in the expiry cycle wins: normal completion, no fault
    assign done      = mem.dmem_ack | expire;
    assign timed_out = expire & ~mem.dmem_ack;

    assign mem.dmem_req   = (state == ACCESS);
    assign mem.dmem_we    = op_we;
    assign mem.dmem_addr  = op_addr;
    assign mem.dmem_wdata = op_wdata;
    assign mem.dmem_be    = op_be;

    assign stall_o = (state != IDLE) | stall_i;

    // select the addressed byte lane of the returned word for byte loads
    always_comb begin
        load_data = mem.dmem_rdata;
        if (op_quarter) begin
            case (op_lane)
                2'd0:    load_data = {24'd0, mem.dmem_rdata[7:0]};
                2'd1:    load_data = {24'd0, mem.dmem_rdata[15:8]};
                2'd2:    load_data = {24'd0, mem.dmem_rdata[23:16]};
                default: load_data = {24'd0, mem.dmem_rdata[31:24]};
            endcase
        end
    end

    // stores and timed-out accesses return the ALU result; a timeout suppresses writeback
    assign res_data  = (op_we | timed_out) ? op_result : load_data;
    assign res_write = op_write & ~timed_out;

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept && is_mem) next_state = ACCESS;
            ACCESS:  if (done) next_state = stall_i ? HOLD : IDLE;
            HOLD:    if (!stall_i) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // capture the memory op on acceptance; bus fields stay constant for the whole access
    always_ff @(posedge clk) begin
        if (accept) begin
            op_we      <= ex_mem_write;
            op_quarter <= ex_quarter;
            op_write   <= ex_write;
            op_lane    <= ex_addr[1:0];
            op_rd      <= ex_rd;
            op_result  <= ex_result;
            op_addr    <= {ex_addr[31:2], 2'b00};
            op_be      <= ex_quarter ? (4'b0001 << ex_addr[1:0]) : 4'hF;
            op_wdata   <= ex_quarter ? {4{ex_wdata[7:0]}} : ex_wdata;
        end
    end

    // MEM/WB output register and HOLD buffer; everything freezes while downstream stalls
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_valid   <= 1'b0;
            wb_write   <= 1'b0;
            wb_quarter <= 1'b0;
            wb_rd      <= 5'd0;
            wb_data    <= 32'd0;
            hold_write <= 1'b0;
            hold_data  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        wb_valid <= ~is_mem;
                        if (!is_mem) begin
                            wb_write   <= ex_write;
                            wb_quarter <= ex_quarter;
                            wb_rd      <= ex_rd;
                            wb_data    <= ex_result;
                        end
                    end else if (!stall_i) begin
                        wb_valid <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (done && stall_i) begin
                        hold_write <= res_write;
                        hold_data  <= res_data;
                    end else if (done) begin
                        wb_valid   <= 1'b1;
                        wb_write   <= res_write;
                        wb_quarter <= op_quarter;
                        wb_rd      <= op_rd;
                        wb_data    <= res_data;
                    end else if (!stall_i) begin
                        wb_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall_i) begin
                        wb_valid   <= 1'b1;
                        wb_write   <= hold_write;
                        wb_quarter <= op_quarter;
                        wb_rd      <= op_rd;
                        wb_data    <= hold_data;
                    end
                end
                default: wb_valid <= 1'b0;
            endcase
        end
    end

`ifdef MEM_ACCESS_TIMEOUT_EN
    // count ACCESS cycles and raise a one-cycle fault when the count expires without an ack
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= 4'd0;
            fault_q <= 1'b0;
        end else begin
            cnt     <= ((state == ACCESS) && !done) ? cnt + 4'd1 : 4'd0;
            fault_q <= timed_out;
        end
    end
`endif
endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - scoreboard testbench for mem_access_stage
module tb_mem_access_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0, ex_write = 1'b0, ex_quarter = 1'b0;
    logic        ex_mem_read = 1'b0, ex_mem_write = 1'b0;
    logic [31:0] ex_addr = '0, ex_wdata = '0, ex_result = '0;
    logic [4:0]  ex_rd = '0;
    logic        stall_i = 1'b0;
    logic        stall_o;
    logic        wb_valid, wb_write, wb_quarter, fault_o;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    mem_access_stage_if mif();

    mem_access_stage dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_write(ex_write), .ex_quarter(ex_quarter),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd), .ex_result(ex_result),
        .stall_i(stall_i), .stall_o(stall_o), .mem(mif.master),
        .wb_valid(wb_valid), .wb_write(wb_write), .wb_quarter(wb_quarter),
        .wb_rd(wb_rd), .wb_data(wb_data), .fault_o(fault_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        write;
        logic        quarter;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic w, input logic q, input logic rd_en, input logic wr_en,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                         input logic [31:0] result, input exp_t e);
        ex_valid = 1'b1; ex_write = w; ex_quarter = q; ex_mem_read = rd_en; ex_mem_write = wr_en;
        ex_addr = addr; ex_wdata = wdata; ex_rd = rd; ex_result = result;
        exp_q.push_back(e);
        tick();
        ex_valid = 1'b0;
    endtask

    task automatic ack_now(input logic [31:0] rdata);
        mif.dmem_ack = 1'b1;
        mif.dmem_rdata = rdata;
        tick();
        mif.dmem_ack = 1'b0;
    endtask

    // monitor: each result is consumed once, on a cycle where downstream is not stalled
    always @(negedge clk) begin
        if (rst_n && wb_valid && !stall_i) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected got rd=%0d data=%h expected no result", wb_rd, wb_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({wb_write, wb_quarter, wb_rd, wb_data} !== e) begin
                    errors++;
                    $display("FAIL wb_result got w=%0b q=%0b rd=%0d data=%h expected w=%0b q=%0b rd=%0d data=%h",
                             wb_write, wb_quarter, wb_rd, wb_data, e.write, e.quarter, e.rd, e.data);
                end
            end
        end
    end

    initial begin
        int scnt;
        mif.dmem_ack = 1'b0;
        mif.dmem_rdata = '0;

        // reset state
        tick(); tick();
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
        chk("rst_dmem_req", {31'd0, mif.dmem_req}, 32'd0);
        chk("rst_fault", {31'd0, fault_o}, 32'd0);
        rst_n = 1'b1;
        tick();

        // ALU op, one-cycle latency
        issue(1, 0, 0, 0, 32'h0, 32'h0, 5'd3, 32'h1234, '{1'b1, 1'b0, 5'd3, 32'h1234});
        chk("alu_wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("alu_stall_o", {31'd0, stall_o}, 32'd0);
        tick();

        // byte load at 0x102, ack in the fourth ACCESS cycle
        issue(1, 1, 1, 0, 32'h102, 32'h0, 5'd5, 32'h0, '{1'b1, 1'b1, 5'd5, 32'h000000BB});
        scnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (stall_o) scnt++;
            chk("bl_req", {31'd0, mif.dmem_req}, 32'd1);
            chk("bl_addr", mif.dmem_addr, 32'h100);
            chk("bl_be", {28'd0, mif.dmem_be}, 32'h4);
            if (i == 3) begin
                mif.dmem_ack = 1'b1;
                mif.dmem_rdata = 32'hAABBCCDD;
            end
            tick();
        end
        mif.dmem_ack = 1'b0;
        chk("bl_stall_cycles", scnt, 32'd4);
        chk("bl_stall_after", {31'd0, stall_o}, 32'd0);
        chk("bl_wb_valid", {31'd0, wb_valid}, 32'd1);

        // byte store at 0x03
        issue(0, 1, 0, 1, 32'h3, 32'h5A, 5'd0, 32'h77, '{1'b0, 1'b1, 5'd0, 32'h77});
        chk("bs_we", {31'd0, mif.dmem_we}, 32'd1);
        chk("bs_be", {28'd0, mif.dmem_be}, 32'h8);
        chk("bs_wdata", mif.dmem_wdata, 32'h5A5A5A5A);
        chk("bs_addr", mif.dmem_addr, 32'h0);
        ack_now(32'h0);

        // read+write together behaves as a word store
        issue(1, 0, 1, 1, 32'h206, 32'hDEADBEEF, 5'd4, 32'h99, '{1'b1, 1'b0, 5'd4, 32'h99});
        chk("rw_we", {31'd0, mif.dmem_we}, 32'd1);
        chk("rw_be", {28'd0, mif.dmem_be}, 32'hF);
        chk("rw_addr", mif.dmem_addr, 32'h204);
        chk("rw_wdata", mif.dmem_wdata, 32'hDEADBEEF);
        ack_now(32'h12345678);

        // word load
        issue(1, 0, 1, 0, 32'h40, 32'h0, 5'd6, 32'h0, '{1'b1, 1'b0, 5'd6, 32'h11223344});
        chk("wl_we", {31'd0, mif.dmem_we}, 32'd0);
        ack_now(32'h11223344);

        // ack under downstream stall: HOLD for two cycles
        issue(1, 0, 1, 0, 32'h80, 32'h0, 5'd7, 32'h0, '{1'b1, 1'b0, 5'd7, 32'hCAFEF00D});
        stall_i = 1'b1;
        ack_now(32'hCAFEF00D);
        chk("hold_wb_valid0", {31'd0, wb_valid}, 32'd0);
        chk("hold_stall_o", {31'd0, stall_o}, 32'd1);
        tick();
        chk("hold_wb_valid1", {31'd0, wb_valid}, 32'd0);
        stall_i = 1'b0;
        tick();
        chk("hold_release", {31'd0, wb_valid}, 32'd1);
        chk("hold_data", wb_data, 32'hCAFEF00D);
        tick();

        // reset mid-ACCESS, then a late ack
        ex_valid = 1'b1; ex_write = 1'b1; ex_quarter = 1'b0; ex_mem_read = 1'b1; ex_mem_write = 1'b0;
        ex_addr = 32'h10; ex_rd = 5'd8;
        tick();
        ex_valid = 1'b0;
        chk("ra_req", {31'd0, mif.dmem_req}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("ra_req_after", {31'd0, mif.dmem_req}, 32'd0);
        chk("ra_wb_valid", {31'd0, wb_valid}, 32'd0);
        ack_now(32'hFFFFFFFF);
        chk("ra_late_ack", {31'd0, wb_valid}, 32'd0);
        chk("ra_stall_o", {31'd0, stall_o}, 32'd0);
        tick();

`ifdef MEM_ACCESS_TIMEOUT_EN
        // no ack: fault in the 17th cycle after entry, writeback suppressed
        issue(1, 0, 1, 0, 32'h20, 32'h0, 5'd9, 32'h55, '{1'b0, 1'b0, 5'd9, 32'h55});
        scnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (mif.dmem_req && !fault_o) scnt++;
            tick();
        end
        chk("to_wait_cycles", scnt, 32'd16);
        chk("to_fault", {31'd0, fault_o}, 32'd1);
        chk("to_req_drop", {31'd0, mif.dmem_req}, 32'd0);
        chk("to_wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("to_wb_write", {31'd0, wb_write}, 32'd0);
        tick();
        chk("to_fault_pulse", {31'd0, fault_o}, 32'd0);

        // ack in the expiry cycle wins
        issue(1, 0, 1, 0, 32'h24, 32'h0, 5'd10, 32'h0, '{1'b1, 1'b0, 5'd10, 32'h600DD00D});
        for (int i = 0; i < 15; i++) tick();
        ack_now(32'h600DD00D);
        chk("te_fault", {31'd0, fault_o}, 32'd0);
        chk("te_wb_write", {31'd0, wb_write}, 32'd1);
        tick();
        chk("te_fault_next", {31'd0, fault_o}, 32'd0);
`else
        // no timeout: the access waits as long as it takes
        issue(1, 0, 1, 0, 32'h20, 32'h0, 5'd9, 32'h0, '{1'b1, 1'b0, 5'd9, 32'h0BADF00D});
        scnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (mif.dmem_req && !fault_o) scnt++;
            tick();
        end
        chk("nt_wait_cycles", scnt, 32'd40);
        ack_now(32'h0BADF00D);
        chk("nt_wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("nt_fault", {31'd0, fault_o}, 32'd0);
`endif

        tick(); tick();
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on posedge.
REQ-002 SHALL have ports: rst_n  in  1  reset, synchronous, active-low.
REQ-003 SHALL have EX/MEM-side inputs: ex_valid 1; ex_write 1 (reg writeback); ex_quarter 1 (byte access); ex_mem_read 1; ex_mem_write 1; ex_addr 32; ex_wdata 32; ex_rd 5; ex_result 32 (ALU result).
REQ-004 SHALL have stall_i  in  1  downstream freeze request from the MEM/WB latch.
REQ-005 SHALL have stall_o  out  1  upstream hold; ex_* are held stable by the source while high.
REQ-006 SHALL have data-memory ports: dmem_req out 1; dmem_we out 1; dmem_addr out 32; dmem_wdata out 32; dmem_be out 4; dmem_ack in 1; dmem_rdata in 32.
REQ-007 SHALL have MEM/WB-side outputs, all registered: wb_valid 1; wb_write 1; wb_quarter 1; wb_rd 5; wb_data 32.
REQ-008 SHALL have fault_o  out  1  one-cycle access-timeout pulse (tied 0 when the timeout feature is compiled out).

Function
REQ-009 SHALL implement FSM states IDLE, ACCESS, HOLD.
REQ-010 SHALL accept ex_* in IDLE when ex_valid=1 and stall_i=0; otherwise hold all wb_* outputs unchanged.
REQ-011 SHALL, for an accepted non-memory op, register wb_valid=1, wb_write=ex_write, wb_quarter=ex_quarter, wb_rd=ex_rd, wb_data=ex_result at that edge (1-cycle latency), remaining in IDLE.
REQ-012 SHALL, for an accepted memory op (ex_mem_read or ex_mem_write), capture the op, enter ACCESS, and register wb_valid=0.
REQ-013 SHALL, in ACCESS, drive dmem_req=1, with dmem_we, dmem_addr, dmem_wdata, dmem_be held constant until the ack cycle.
REQ-014 SHALL, for ex_mem_read and ex_mem_write both set, treat the op as a write.
REQ-015 SHALL, for word access, drive dmem_addr={addr[31:2],2'b00} and dmem_be=4'hF.
REQ-016 SHALL, for byte access, drive dmem_be=4'b0001<<addr[1:0] and dmem_wdata={4{wdata[7:0]}}.
REQ-017 SHALL return load data as dmem_rdata for word access, and as the byte at lane addr[1:0], zero-extended, for byte access.
REQ-018 SHALL return wb_data=ex_result for stores.
REQ-019 SHALL, on dmem_ack in ACCESS with stall_i=0, register the wb_* result with wb_valid=1 and return to IDLE.
REQ-020 SHALL, on dmem_ack in ACCESS with stall_i=1, buffer the result and enter HOLD; HOLD releases it to wb_* on the first cycle stall_i=0, then enters IDLE.
REQ-021 SHALL drive stall_o=1 in ACCESS and HOLD, and whenever stall_i=1; otherwise 0.
REQ-022 SHALL clear wb_valid after one cycle of presentation unless a new result is registered, except that wb_* hold while stall_i=1.
REQ-023 SHALL ignore dmem_ack outside ACCESS.

Reset
REQ-024 SHALL, on rst_n=0 at posedge, enter IDLE and drive wb_valid=0, wb_write=0, wb_quarter=0, wb_rd=0, wb_data=0, dmem_req=0, fault_o=0, and timeout counter=0.
REQ-025 SHALL abort an in-flight ACCESS or HOLD on reset with no writeback; a late ack afterwards is ignored.

Configuration
REQ-026 SHALL, with MEM_ACCESS_TIMEOUT_EN defined, count cycles in ACCESS with a 4-bit counter; if 16 cycles elapse without ack, it SHALL drop dmem_req, pulse fault_o for 1 cycle, emit wb_valid=1 with wb_write=0, and return to IDLE.
REQ-027 SHALL, under MEM_ACCESS_TIMEOUT_EN, give ack priority if it arrives in the same cycle the counter expires (normal completion, no fault).
REQ-028 SHALL, without MEM_ACCESS_TIMEOUT_EN, wait in ACCESS indefinitely and tie fault_o=0.

Verification
REQ-029 SHALL cover ALU op: ex_result=0x1234, rd=3, write=1 -> next cycle wb_valid=1, wb_data=0x1234, wb_rd=3, stall_o=0.
REQ-030 SHALL cover byte load: addr=0x102, rdata=0xAABBCCDD, ack after 3 cycles -> dmem_be=0100, dmem_addr=0x100, wb_data=0x000000BB, stall_o high for 4 cycles.
REQ-031 SHALL cover byte store: addr=0x03, wdata=0x5A -> dmem_we=1, be=1000, dmem_wdata=0x5A5A5A5A.
REQ-032 SHALL cover ack with stall_i=1 for 2 cycles -> HOLD, wb_valid stays 0, then result appears the cycle after stall_i falls.
REQ-033 SHALL cover reset asserted mid-ACCESS -> dmem_req=0 and wb_valid=0 next cycle, and a following ack is ignored.
REQ-034 SHALL cover, with MEM_ACCESS_TIMEOUT_EN, no ack -> fault_o pulse on the 17th cycle after entry with wb_write=0; ack in the expiry cycle -> normal completion, fault_o=0.
